// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider: operands travel with in_valid/in_ready,
// results with out_valid/out_ready.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock; WIDTH cycles (WIDTH+1 with SEQ_DIVIDER_SIGNED_EN), 1 for /0.
// Single op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave dif
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  // The core only ever sees magnitudes; signs are reapplied in FIX.
  assign a_mag = dif.dividend[WIDTH-1] ? -dif.dividend : dif.dividend;
  assign b_mag = dif.divisor[WIDTH-1]  ? -dif.divisor  : dif.divisor;
`else
  assign a_mag = dif.dividend;
  assign b_mag = dif.divisor;
`endif

  // rem < divisor always holds, so WIDTH bits suffice; the shift adds the extra bit.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (dif.in_valid) begin
          if (dif.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dif.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            cnt_d   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_d = dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1];
            neg_rem_d = dif.dividend[WIDTH-1];
`endif
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
      FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        quo_d = neg_quo_q ? -quo_q : quo_q;
        rem_d = neg_rem_q ? -rem_q : rem_q;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (dif.out_ready) begin
          state_d = IDLE;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  assign dif.in_ready    = (state_q == IDLE);
  assign dif.out_valid   = (state_q == DONE);
  assign dif.quotient    = quo_q;
  assign dif.remainder   = rem_q;
  assign dif.div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential radix-2 restoring unsigned integer divider. It is the inverse operation to the team's combinational Wallace-tree multipliers.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Valid/ready handshakes on input and output, so it drops into the arithmetic datapath next to the multiplier blocks.
- Intended for the multiply/divide unit and for bench cross-checks of product = quotient*divisor + remainder.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (min 2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  divisor was zero for this result.

Behaviour:
- Interface: one clock clk; reset rst_n, asynchronous, active-low.
- Reset values (asserted at any time, including mid-operation): FSM=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Any in-flight operation is discarded and no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, operands are captured at the clock edge.
  - If divisor==0: go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Otherwise: go to CALC with working regs rem(WIDTH+1 bits)=0, quo=dividend, divisor latched, count=0.
- CALC:
  - in_ready=0.
  - Each cycle: {rem,quo} shift left 1; trial=rem-{0,divisor} at WIDTH+1 bits.
  - If trial non-negative (MSB=0): rem=trial, quo[0]=1; else rem unchanged and quo[0]=0.
  - count increments. After iteration WIDTH (count==WIDTH-1 at the edge), go to DONE.
- DONE:
  - out_valid=1, quotient=quo, remainder=rem[WIDTH-1:0], in_ready=0.
  - Outputs stay stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0, div_by_zero cleared.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge for a nonzero divisor, 1 cycle for a zero divisor.
- Throughput: one operation in flight. Next accept is possible in the cycle after output handshake; no same-cycle output-accept/input-accept overlap (in_ready is 0 in DONE).
- in_valid while busy is ignored; the source holds its operands.
- Operand inputs are sampled only on the accept edge; later changes have no effect.
- Invariant for nonzero divisor: dividend == quotient*divisor + remainder, remainder < divisor.
- Corner cases:
  - Divisor > dividend: quotient=0, remainder=dividend.
  - Dividend 0: quotient 0, remainder 0, full WIDTH latency (no early termination).

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- When defined:
  - Operands and results are two's complement.
  - Magnitudes are divided by the same unsigned core. Quotient is negated when the operand signs differ (truncation toward zero). Remainder takes the dividend's sign.
  - Sign fix-up is registered in one extra cycle, so latency becomes WIDTH+1.
  - Most-negative / -1 wraps: quotient=most-negative, remainder=0, no flag.
  - Zero divisor gives quotient=all ones, remainder=dividend, div_by_zero=1, latency 1.
- When undefined: pure unsigned as above, no extra cycle.

Test Plan:
- WIDTH=8, dividend=200, divisor=7, out_ready=1 -> out_valid exactly 8 cycles after accept, quotient=28, remainder=4, div_by_zero=0, in_ready back to 1 the cycle after handshake.
- dividend=255, divisor=1 then dividend=3, divisor=10 back-to-back -> (255,0) then (0,3); in_valid held during the first op is not accepted early.
- dividend=5, divisor=0 -> out_valid 1 cycle after accept, quotient=0xFF, remainder=5, div_by_zero=1; flag clears after the handshake.
- dividend=100, divisor=9 with out_ready=0 for 5 cycles after out_valid -> quotient=11, remainder=1 held stable, in_ready=0 throughout; released on out_ready=1.
- rst_n pulsed low asynchronously at iteration 4 of 200/7 -> out_valid=0, in_ready=1 immediately; a fresh 200/7 then completes correctly with no stale result.
- SEQ_DIVIDER_SIGNED_EN defined: -7/2 -> quotient=0xFD, remainder=0xFF after 9 cycles; -128/-1 -> quotient=0x80, remainder=0.
